pb_periph_hub: RTL and testbench
================================

// Module: pb_periph_hub
// PURPOSE
//  Parametrised PicoBlaze (pacoblaze3) peripheral hub: full-address-decoded I/O register file,
//  NUM_TIMERS programmable millisecond interval timers, external edge IRQ, masked interrupt
//  controller with ack handshake. Sits between pacoblaze3 port bus and board I/O (LEDs, switches).
// PARAMETERS
//  CLK_FREQ_HZ    25000000  input clock frequency; 1 ms tick = CLK_FREQ_HZ/1000 cycles
//  NUM_TIMERS     2         interval timer channels, 1..7 (pending bits [NUM_TIMERS-1:0])
//  NUM_OUT_PORTS  4         8-bit output registers at port_id 0x80+n, 1..16
// PORTS
//  clk            in   1                system clock, all state on posedge
//  reset_n        in   1                asynchronous active-low reset
//  port_id        in   8                processor port address
//  out_port       in   8                processor write data
//  write_strobe   in   1                write qualifier, one cycle
//  read_strobe    in   1                read qualifier (side effects only, see below)
//  in_port        out  8                registered read data
//  interrupt      out  1                interrupt request to processor
//  interrupt_ack  in   1                processor acknowledge, one-cycle pulse
//  input_data     in   8                switch/general input (async, sampled via 2-FF sync)
//  ext_irq        in   1                external async event, rising edge -> pending[7]
//  out_regs       out  8*NUM_OUT_PORTS  output port registers, port n in bits [8n+7:8n]
// BEHAVIOUR
//  Reset: in_port=0, interrupt=0, out_regs=0, mask=0, pending=0, all timers disabled, reload=0.
//  Register map (exact port_id match; unmapped reads return 0x00, unmapped/RO writes ignored):
//   0x00 R  input_data (synchronised)     0x01 R  pending[7:0]
//   0x02 RW mask[7:0]                     0x03 W  write-1-to-clear pending
//   0x10+2k W timer k reload low (shadow)  0x11+2k W timer k reload high (commits {hi,shadow})
//   0x20+k RW timer k ctrl: bit0 enable, bit1 one_shot; reads return current ctrl bits
//   0x80+n RW out_regs[n]
//  Reads: in_port registered from port_id every cycle -> data valid 1 cycle after port_id.
//  ms prescaler: free-running, wraps at CLK_FREQ_HZ/1000-1, emits 1-cycle tick.
//  Timer k: 16-bit down-counter. Writing ctrl with enable 0->1 loads count=reload.
//   On tick while enabled: count==1 -> set pending[k], count<=reload; one_shot also clears enable.
//   Otherwise count decrements. reload==0: timer never fires. Reload commit mid-run takes
//   effect at next reload; disabling freezes count.
//  ext_irq: 2-FF sync + edge detect; rising edge sets pending[7] one cycle after sync.
//  Set beats clear: a pending set and W1C of the same bit in one cycle leaves the bit set.
//  IRQ FSM (interrupt registered):
//   IDLE: (pending&mask)!=0 -> ASSERT, interrupt<=1.
//   ASSERT: interrupt_ack -> SERVICE, interrupt<=0. Stays asserted until ack.
//   SERVICE: any write to 0x03 -> IDLE (re-evaluates next cycle, so leftover bits re-fire).
//  Masking a bit while in ASSERT does not drop interrupt; ack still required.
//  Reset mid-operation: all state to reset values immediately; no pending survives.
// STRUCTURE
//  Package pb_periph_pkg: port address constants (PB_ADDR_INPUT, PB_ADDR_PENDING, PB_ADDR_MASK,
//   PB_ADDR_CLEAR, PB_ADDR_TMR_BASE, PB_ADDR_TMR_CTRL, PB_ADDR_OUT_BASE), IRQ state encodings,
//   EXT_IRQ_BIT=7.
//  Sub-module pb_interval_timer (one channel: reload shadow, counter, ctrl, fire pulse),
//   generated NUM_TIMERS times; prescaler, decode, IRQ FSM, sync in the top.
// TESTING
//  Reset with all inputs toggling -> all outputs 0, interrupt low for 10 us.
//  Write 0x55 to 0x81, read 0x81 -> in_port 0x55 one cycle after port_id; out_regs[15:8]=0x55.
//  CLK_FREQ_HZ=1000000, timer0 reload 0x0003, ctrl=0x01, mask=0x01 -> pending[0] and interrupt
//   3 ms (+/-1 tick) after enable, repeating every 3 ms.
//  One-shot timer1 reload 2 -> fires once at 2 ms, ctrl reads 0x02 afterwards, no further sets.
//  ext_irq edge, mask=0x80 -> interrupt; ack -> interrupt 0; write 0x80 to 0x03 -> stays low;
//   second edge before clear -> interrupt reasserts right after clear.
//  Timer fire coincident with W1C of same bit -> pending bit remains 1.

Source files
------------

// File: rtl/pb_periph_pkg.sv
// Shared constants for the PicoBlaze peripheral hub: port map, IRQ FSM states.
package pb_periph_pkg;

  localparam logic [7:0] PB_ADDR_INPUT    = 8'h00;
  localparam logic [7:0] PB_ADDR_PENDING  = 8'h01;
  localparam logic [7:0] PB_ADDR_MASK     = 8'h02;
  localparam logic [7:0] PB_ADDR_CLEAR    = 8'h03;
  localparam logic [7:0] PB_ADDR_TMR_BASE = 8'h10;
  localparam logic [7:0] PB_ADDR_TMR_CTRL = 8'h20;
  localparam logic [7:0] PB_ADDR_OUT_BASE = 8'h80;

  localparam int EXT_IRQ_BIT = 7;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_ASSERT  = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/pb_interval_timer.sv
// One millisecond interval timer channel: reload shadow, 16-bit down-counter,
// enable/one-shot control and a single-cycle fire pulse on expiry.
module pb_interval_timer
  import pb_periph_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       wr_lo,
  input  logic       wr_hi,
  input  logic       wr_ctrl,
  input  logic [7:0] wdata,
  output logic [1:0] ctrl,
  output logic       fire
);

  logic [7:0]  shadow;
  logic [15:0] reload;
  logic [15:0] count;
  logic        enable;
  logic        one_shot;

  assign ctrl = {one_shot, enable};
  // A zero reload parks the channel; it never fires.
  assign fire = tick && enable && (reload != 16'd0) && (count == 16'd1);

  // Reload staging, control writes and millisecond countdown.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow   <= 8'h00;
      reload   <= 16'h0000;
      count    <= 16'h0000;
      enable   <= 1'b0;
      one_shot <= 1'b0;
    end else begin
      if (wr_lo) shadow <= wdata;
      // Committing a new reload does not touch a running count.
      if (wr_hi) reload <= {wdata, shadow};
      if (wr_ctrl) begin
        enable   <= wdata[0];
        one_shot <= wdata[1];
        if (!enable && wdata[0]) count <= reload;
      end else if (tick && enable && (reload != 16'd0)) begin
        if (count == 16'd1) begin
          count <= reload;
          if (one_shot) enable <= 1'b0;
        end else if (count == 16'd0) begin
          // Armed while reload was still zero: pick up the new reload quietly.
          count <= reload;
        end else begin
          count <= count - 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/pb_periph_hub.sv
// PicoBlaze peripheral hub: decoded I/O registers, interval timers, external
// edge IRQ and a masked interrupt controller with acknowledge handshake.
module pb_periph_hub
  import pb_periph_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 25000000,
  parameter int NUM_TIMERS    = 2,
  parameter int NUM_OUT_PORTS = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [7:0]                 port_id,
  input  logic [7:0]                 out_port,
  input  logic                       write_strobe,
  input  logic                       read_strobe,
  output logic [7:0]                 in_port,
  output logic                       interrupt,
  input  logic                       interrupt_ack,
  input  logic [7:0]                 input_data,
  input  logic                       ext_irq,
  output logic [8*NUM_OUT_PORTS-1:0] out_regs
);

  localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
  localparam int PW       = $clog2(TICK_DIV + 1);

  logic [7:0]            in_sync_p0, in_sync_p1;
  logic                  ext_p0, ext_p1, ext_p2;
  logic                  ext_rise;
  logic [PW-1:0]         presc;
  logic                  tick;
  logic [7:0]            out_q [NUM_OUT_PORTS];
  logic [7:0]            mask;
  logic [7:0]            pending;
  logic [7:0]            set_vec;
  logic [7:0]            clr_vec;
  logic [7:0]            rdata;
  logic                  wr_clear;
  logic [NUM_TIMERS-1:0] fire;
  logic [1:0]            tmr_ctrl [NUM_TIMERS];
  irq_state_t            state_q, state_d;
  logic                  irq_d;

  // Reads have no side effects in this hub.
  logic unused_read_strobe;
  assign unused_read_strobe = read_strobe;

  // Two-flop synchronisers for switches and the external event, plus edge history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_sync_p0 <= 8'h00;
      in_sync_p1 <= 8'h00;
      ext_p0     <= 1'b0;
      ext_p1     <= 1'b0;
      ext_p2     <= 1'b0;
    end else begin
      in_sync_p0 <= input_data;
      in_sync_p1 <= in_sync_p0;
      ext_p0     <= ext_irq;
      ext_p1     <= ext_p0;
      ext_p2     <= ext_p1;
    end
  end

  assign ext_rise = ext_p1 & ~ext_p2;

  assign tick = (presc == PW'(TICK_DIV - 1));

  // Free-running millisecond prescaler.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) presc <= '0;
    else          presc <= tick ? '0 : presc + 1'b1;
  end

  for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_tmr
    pb_interval_timer u_tmr (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .wr_lo   (write_strobe && (port_id == 8'(PB_ADDR_TMR_BASE + 2*k))),
      .wr_hi   (write_strobe && (port_id == 8'(PB_ADDR_TMR_BASE + 2*k + 1))),
      .wr_ctrl (write_strobe && (port_id == 8'(PB_ADDR_TMR_CTRL + k))),
      .wdata   (out_port),
      .ctrl    (tmr_ctrl[k]),
      .fire    (fire[k])
    );
  end

  assign wr_clear = write_strobe && (port_id == PB_ADDR_CLEAR);
  assign clr_vec  = wr_clear ? out_port : 8'h00;

  // Collect pending sources: timer fires in the low bits, external edge on top.
  always_comb begin
    set_vec                  = 8'h00;
    set_vec[NUM_TIMERS-1:0]  = fire;
    set_vec[EXT_IRQ_BIT]     = ext_rise;
  end

  // Writable registers; a set in the same cycle as its clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask    <= 8'h00;
      pending <= 8'h00;
      for (int n = 0; n < NUM_OUT_PORTS; n++) out_q[n] <= 8'h00;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
      if (write_strobe && (port_id == PB_ADDR_MASK)) mask <= out_port;
      for (int n = 0; n < NUM_OUT_PORTS; n++) begin
        if (write_strobe && (port_id == 8'(PB_ADDR_OUT_BASE + n))) out_q[n] <= out_port;
      end
    end
  end

  for (genvar n = 0; n < NUM_OUT_PORTS; n++) begin : g_out
    assign out_regs[8*n +: 8] = out_q[n];
  end

  // Exact-match read decode; anything unmapped reads as zero.
  always_comb begin
    rdata = 8'h00;
    if (port_id == PB_ADDR_INPUT)   rdata = in_sync_p1;
    if (port_id == PB_ADDR_PENDING) rdata = pending;
    if (port_id == PB_ADDR_MASK)    rdata = mask;
    for (int k = 0; k < NUM_TIMERS; k++) begin
      if (port_id == 8'(PB_ADDR_TMR_CTRL + k)) rdata = {6'b000000, tmr_ctrl[k]};
    end
    for (int n = 0; n < NUM_OUT_PORTS; n++) begin
      if (port_id == 8'(PB_ADDR_OUT_BASE + n)) rdata = out_q[n];
    end
  end

  // Read data is registered, valid one cycle after port_id.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) in_port <= 8'h00;
    else          in_port <= rdata;
  end

  // Interrupt controller next-state and request level.
  always_comb begin
    state_d = state_q;
    irq_d   = 1'b0;
    case (state_q)
      IRQ_IDLE: begin
        if ((pending & mask) != 8'h00) begin
          state_d = IRQ_ASSERT;
          irq_d   = 1'b1;
        end
      end
      IRQ_ASSERT: begin
        // Held until acknowledged, even if the source gets masked meanwhile.
        irq_d = 1'b1;
        if (interrupt_ack) begin
          state_d = IRQ_SERVICE;
          irq_d   = 1'b0;
        end
      end
      IRQ_SERVICE: begin
        if (wr_clear) state_d = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  // Interrupt controller state and registered request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IRQ_IDLE;
      interrupt <= 1'b0;
    end else begin
      state_q   <= state_d;
      interrupt <= irq_d;
    end
  end

endmodule

// File: tb/tb_pb_periph_hub.sv
// Directed bench for pb_periph_hub at a 1 MHz clock (1 ms = 1000 cycles).
`timescale 1ns/1ps
module tb_pb_periph_hub;

  localparam int CLK_FREQ_HZ   = 1000000;
  localparam int NUM_TIMERS    = 2;
  localparam int NUM_OUT_PORTS = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  port_id = 8'h00;
  logic [7:0]  out_port = 8'h00;
  logic        write_strobe = 1'b0;
  logic        read_strobe = 1'b0;
  logic [7:0]  in_port;
  logic        interrupt;
  logic        interrupt_ack = 1'b0;
  logic [7:0]  input_data = 8'h00;
  logic        ext_irq = 1'b0;
  logic [8*NUM_OUT_PORTS-1:0] out_regs;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pb_periph_hub #(
    .CLK_FREQ_HZ   (CLK_FREQ_HZ),
    .NUM_TIMERS    (NUM_TIMERS),
    .NUM_OUT_PORTS (NUM_OUT_PORTS)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .port_id       (port_id),
    .out_port      (out_port),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .input_data    (input_data),
    .ext_irq       (ext_irq),
    .out_regs      (out_regs)
  );

  always #500 clk = ~clk;

  // Cycles since reset release; tick edges are the posedges where this hits a multiple of 1000.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  initial begin
    #60_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    port_id = a; out_port = d; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    @(negedge clk);
    port_id = a; read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
    v = in_port;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
  endtask

  // Return the interrupt controller to idle with nothing pending or unmasked.
  task automatic irq_idle();
    wr(8'h02, 8'h00);
    ack_pulse();
    wr(8'h03, 8'hFF);
  endtask

  task automatic wait_irq(input int limit, output bit got, output int when);
    got = 1'b0; when = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (interrupt) begin got = 1'b1; when = cyc; break; end
    end
  endtask

  task automatic wait_phase(input int ph, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ((cyc % 1000) == ph) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] v;
    bit got, ok;
    int t0, t1, t2;

    // Reset held while every input toggles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      port_id = 8'($urandom); out_port = 8'($urandom); input_data = 8'($urandom);
      write_strobe = ~write_strobe; read_strobe = ~read_strobe;
      interrupt_ack = ~interrupt_ack; ext_irq = ~ext_irq;
      #1 check_val("rst_interrupt", {31'b0, interrupt}, 32'h0);
    end
    check_val("rst_in_port", {24'b0, in_port}, 32'h0);
    check_val("rst_out_regs", out_regs, 32'h0);
    @(negedge clk);
    port_id = 8'h00; out_port = 8'h00; input_data = 8'h00;
    write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0; ext_irq = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    rd(8'h02, v); check_val("rst_mask", {24'b0, v}, 32'h00);
    rd(8'h01, v); check_val("rst_pending", {24'b0, v}, 32'h00);
    rd(8'h20, v); check_val("rst_ctrl0", {24'b0, v}, 32'h00);

    // Output registers and read latency
    wr(8'h81, 8'h55);
    check_val("out1_regs", out_regs, 32'h0000_5500);
    @(negedge clk); port_id = 8'h00;
    @(negedge clk); port_id = 8'h81;
    #1 check_val("rd_latency_before", {24'b0, in_port}, 32'h00);
    @(negedge clk);
    check_val("rd_latency_after", {24'b0, in_port}, 32'h55);
    wr(8'h83, 8'hA3);
    check_val("out3_regs", out_regs, 32'hA300_5500);
    wr(8'h84, 8'hEE);
    check_val("unmapped_wr", out_regs, 32'hA300_5500);
    rd(8'h84, v); check_val("unmapped_rd", {24'b0, v}, 32'h00);
    input_data = 8'h3C;
    repeat (3) @(negedge clk);
    rd(8'h00, v); check_val("input_sync", {24'b0, v}, 32'h3C);
    wr(8'h02, 8'h81);
    rd(8'h02, v); check_val("mask_rw", {24'b0, v}, 32'h81);
    wr(8'h01, 8'hFF);
    rd(8'h01, v); check_val("pending_ro", {24'b0, v}, 32'h00);
    wr(8'h02, 8'h00);

    // Timer 0 periodic, 3 ms
    wr(8'h10, 8'h03); wr(8'h11, 8'h00); wr(8'h02, 8'h01);
    wr(8'h20, 8'h01); t0 = cyc;
    wait_irq(5000, got, t1);
    check_val("tmr0_irq_seen", {31'b0, got}, 32'h1);
    check_val("tmr0_first_delay", {31'b0, (t1 - t0 >= 2001 && t1 - t0 <= 3001)}, 32'h1);
    rd(8'h01, v); check_val("tmr0_pending", {24'b0, v}, 32'h01);
    rd(8'h20, v); check_val("tmr0_ctrl", {24'b0, v}, 32'h01);
    ack_pulse();
    check_val("tmr0_ack_drop", {31'b0, interrupt}, 32'h0);
    wr(8'h03, 8'h01);
    wait_irq(4000, got, t2);
    check_val("tmr0_irq_repeat", {31'b0, got}, 32'h1);
    check_val("tmr0_period", t2 - t1, 32'd3000);
    wr(8'h20, 8'h00);
    irq_idle();

    // Timer fire coincident with write-1-to-clear: set wins
    wr(8'h10, 8'h01); wr(8'h11, 8'h00); wr(8'h20, 8'h01);
    wait_phase(200, ok);
    check_val("sbc_phase_a", {31'b0, ok}, 32'h1);
    wr(8'h03, 8'h01);
    rd(8'h01, v); check_val("plain_clear", {24'b0, v}, 32'h00);
    wait_phase(999, ok);
    check_val("sbc_phase_b", {31'b0, ok}, 32'h1);
    port_id = 8'h03; out_port = 8'h01; write_strobe = 1'b1;
    @(negedge clk); write_strobe = 1'b0;
    rd(8'h01, v); check_val("set_beats_clear", {24'b0, v}, 32'h01);
    wr(8'h20, 8'h00);
    irq_idle();

    // One-shot timer 1, reload 2
    wr(8'h12, 8'h02); wr(8'h13, 8'h00); wr(8'h03, 8'hFF);
    wr(8'h21, 8'h03); t0 = cyc;
    @(negedge clk); port_id = 8'h01;
    got = 1'b0; t1 = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (in_port[1]) begin got = 1'b1; t1 = cyc; break; end
    end
    check_val("os_fired", {31'b0, got}, 32'h1);
    check_val("os_delay", {31'b0, (t1 - t0 >= 1002 && t1 - t0 <= 2001)}, 32'h1);
    rd(8'h21, v); check_val("os_ctrl_after", {24'b0, v}, 32'h02);
    wr(8'h03, 8'h02);
    repeat (3500) @(negedge clk);
    rd(8'h01, v); check_val("os_no_refire", {24'b0, v}, 32'h00);

    // External edge IRQ with ack / clear handshake
    wr(8'h02, 8'h80);
    @(negedge clk); ext_irq = 1'b1;
    wait_irq(10, got, t1);
    check_val("ext_irq_seen", {31'b0, got}, 32'h1);
    ext_irq = 1'b0;
    ack_pulse();
    check_val("ext_ack_drop", {31'b0, interrupt}, 32'h0);
    wr(8'h03, 8'h80);
    repeat (5) @(negedge clk);
    check_val("ext_stays_low", {31'b0, interrupt}, 32'h0);
    rd(8'h01, v); check_val("ext_pending_clr", {24'b0, v}, 32'h00);
    @(negedge clk); ext_irq = 1'b1;
    wait_irq(10, got, t1);
    check_val("ext_irq_again", {31'b0, got}, 32'h1);
    ext_irq = 1'b0;
    repeat (3) @(negedge clk);
    ack_pulse();
    check_val("ext_ack_drop2", {31'b0, interrupt}, 32'h0);
    // Second edge lands in the same cycle as the clear write
    @(negedge clk); ext_irq = 1'b1;
    @(negedge clk);
    @(negedge clk); port_id = 8'h03; out_port = 8'h80; write_strobe = 1'b1;
    @(negedge clk); write_strobe = 1'b0; ext_irq = 1'b0;
    check_val("ext_clear_cycle", {31'b0, interrupt}, 32'h0);
    @(negedge clk);
    check_val("ext_refire", {31'b0, interrupt}, 32'h1);
    rd(8'h01, v); check_val("ext_pending_kept", {24'b0, v}, 32'h80);

    // Reset mid-operation
    @(negedge clk); reset_n = 1'b0;
    #1 check_val("midrst_interrupt", {31'b0, interrupt}, 32'h0);
    check_val("midrst_out_regs", out_regs, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd(8'h01, v); check_val("midrst_pending", {24'b0, v}, 32'h00);
    rd(8'h02, v); check_val("midrst_mask", {24'b0, v}, 32'h00);
    rd(8'h21, v); check_val("midrst_ctrl1", {24'b0, v}, 32'h00);
    repeat (3) @(negedge clk);
    check_val("midrst_irq_low", {31'b0, interrupt}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
